// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined right shifter: default geometry,
// the per-stage record layout and a small helper for stage step sizes.
package shift_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_SHAMT_W = $clog2(DEF_WIDTH);

  // One pipeline stage worth of state: valid bit, partially shifted data,
  // the shift amount still being carried along, and the fill mode.
  typedef struct packed {
    logic                   valid;
    logic [DEF_WIDTH-1:0]   data;
    logic [DEF_SHAMT_W-1:0] shamt;
    logic                   arith;
  } stage_t;

  // Stage idx shifts by 2^idx when shamt bit idx is set.
  function automatic int stepOf(input int idx);
    return 1 << idx;
  endfunction

endpackage

// File: rtl/shr_stage.sv
// One registered stage of the right shifter. It shifts the upstream data
// right by STEP when the matching shamt bit is set, keeps its own valid
// bit, and produces its enable for the ready chain.
module shr_stage
  import shift_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               i_upValid,
  input  logic [WIDTH-1:0]   i_upData,
  input  logic [SHAMT_W-1:0] i_upShamt,
  input  logic               i_upArith,
  input  logic               i_enNext,
  output logic               o_en,
  output logic               o_valid,
  output logic [WIDTH-1:0]   o_data,
  output logic [SHAMT_W-1:0] o_shamt,
  output logic               o_arith
);

  localparam int BIT = $clog2(STEP);

  logic               r_valid;
  logic [WIDTH-1:0]   r_data;
  logic [SHAMT_W-1:0] r_shamt;
  logic               r_arith;

  logic               w_en;
  logic               w_fill;
  logic               w_load;
  logic [WIDTH-1:0]   w_shifted;
  logic [WIDTH-1:0]   w_next;

  // A stage may take new contents when it is empty or its successor moves.
  always_comb begin
    w_en = ~r_valid | i_enNext;
  end

  // Arithmetic shifts replicate the operand's top bit, which every earlier
  // arithmetic stage has preserved in place; logical shifts fill with zero.
  always_comb begin
    w_fill    = i_upArith & i_upData[WIDTH-1];
    w_shifted = {{STEP{w_fill}}, i_upData[WIDTH-1:STEP]};
    w_next    = i_upShamt[BIT] ? w_shifted : i_upData;
    w_load    = w_en & i_upValid & ~flush;
  end

  // Valid advances on enable and is wiped by flush; payload only loads when
  // a real operation moves in, so bubbles and flushes leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_shamt <= '0;
      r_arith <= 1'b0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_en) begin
        r_valid <= i_upValid;
      end
      if (w_load) begin
        r_data  <= w_next;
        r_shamt <= i_upShamt;
        r_arith <= i_upArith;
      end
    end
  end

  assign o_en    = w_en;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_shamt = r_shamt;
  assign o_arith = r_arith;

endmodule

// File: rtl/srl_pipe.sv
// Pipelined 16-bit right shifter (logical or arithmetic) with a valid/ready
// handshake. Each of the SHAMT_W stages handles one shamt bit; the ready
// chain is purely combinational from out_ready, so a full pipeline can
// accept and retire in the same cycle.
module srl_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   Ain,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   Aout
);

  logic [SHAMT_W:0]   w_en;
  logic [SHAMT_W-1:0] w_valid;
  logic [SHAMT_W-1:0] w_arith;
  logic [WIDTH-1:0]   w_data  [SHAMT_W];
  logic [SHAMT_W-1:0] w_shamt [SHAMT_W];

  // The output stage can always advance when the consumer is ready.
  assign w_en[SHAMT_W] = out_ready;

  for (genvar g = 0; g < SHAMT_W; g++) begin : gStage
    logic               w_upValid;
    logic [WIDTH-1:0]   w_upData;
    logic [SHAMT_W-1:0] w_upShamt;
    logic               w_upArith;

    if (g == 0) begin : gHead
      assign w_upValid = in_valid;
      assign w_upData  = Ain;
      assign w_upShamt = shamt;
      assign w_upArith = arith;
    end else begin : gBody
      assign w_upValid = w_valid[g-1];
      assign w_upData  = w_data[g-1];
      assign w_upShamt = w_shamt[g-1];
      assign w_upArith = w_arith[g-1];
    end

    shr_stage #(
      .WIDTH  (WIDTH),
      .SHAMT_W(SHAMT_W),
      .STEP   (stepOf(g))
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .i_upValid(w_upValid),
      .i_upData (w_upData),
      .i_upShamt(w_upShamt),
      .i_upArith(w_upArith),
      .i_enNext (w_en[g+1]),
      .o_en     (w_en[g]),
      .o_valid  (w_valid[g]),
      .o_data   (w_data[g]),
      .o_shamt  (w_shamt[g]),
      .o_arith  (w_arith[g])
    );
  end

  // Nothing is taken in while a flush is being applied.
  assign in_ready  = w_en[0] & ~flush;
  assign out_valid = w_valid[SHAMT_W-1];
  assign Aout      = w_data[SHAMT_W-1];

  // The last stage's shamt and fill mode have no further consumer.
  logic w_unused_tail;
  assign w_unused_tail = ^{w_shamt[SHAMT_W-1], w_arith[SHAMT_W-1]};

endmodule

// File: tb/tb_srl_pipe.sv
// Self-checking bench for srl_pipe: table of single shifts with latency
// checks, directed throughput/backpressure/flush/reset sequences, and a
// randomized run checked against a queue-based reference model.
module tb_srl_pipe;
  import shift_pkg::*;

  localparam int W = DEF_WIDTH;
  localparam int S = DEF_SHAMT_W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] Ain;
  logic [S-1:0] shamt;
  logic         arith;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Aout;

  always #5 clk = ~clk;

  srl_pipe #(.WIDTH(W), .SHAMT_W(S)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Ain      (Ain),
    .shamt    (shamt),
    .arith    (arith),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Aout     (Aout)
  );

  typedef struct {
    logic [W-1:0] ain;
    logic [S-1:0] sh;
    logic         ar;
    logic [W-1:0] exp;
  } vec_t;

  int testsRun    = 0;
  int testsFailed = 0;
  int cycleNo     = 0;
  int outCount    = 0;
  int firstOutCycle = 0;
  int lastOutCycle  = 0;

  stage_t       modelQ[$];
  logic [W-1:0] gotQ[$];

  // Reference: a right shift is floor division by 2^n, sign-preserving when arithmetic.
  function automatic logic [W-1:0] refShift(input stage_t e);
    logic signed [W-1:0] sd;
    sd = e.data;
    if (e.arith) return sd >>> e.shamt;
    return e.data >> e.shamt;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [S-1:0] s, input logic ar);
    in_valid = v;
    Ain      = a;
    shamt    = s;
    arith    = ar;
  endtask

  // One clock cycle: check ready against the model, score any output
  // handshake, record any accepted input, then advance past the edge.
  task automatic tick();
    stage_t e;
    logic   expReady;
    #1;
    expReady = !flush && ((modelQ.size() < S) || out_ready);
    checkOutput("in_ready", in_ready, expReady);
    if (out_valid && out_ready) begin
      checkOutput("out_has_pending", modelQ.size() > 0, 1);
      if (modelQ.size() > 0) begin
        e = modelQ.pop_front();
        checkOutput("out_data", Aout, refShift(e));
      end
      if (outCount == 0) firstOutCycle = cycleNo;
      lastOutCycle = cycleNo;
      outCount++;
      gotQ.push_back(Aout);
    end
    if (flush) begin
      modelQ.delete();
    end else if (in_valid && in_ready) begin
      e.valid = 1'b1;
      e.data  = Ain;
      e.shamt = shamt;
      e.arith = arith;
      modelQ.push_back(e);
    end
    @(posedge clk);
    #1;
    cycleNo++;
  endtask

  // Issue one shift into an idle pipeline and measure when it appears.
  task automatic runOne(input string name, input vec_t v);
    int lat;
    out_ready = 1'b1;
    flush     = 1'b0;
    applyStimulus(1'b1, v.ain, v.sh, v.ar);
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    checkOutput({name, "_latency"}, lat, 3);
    checkOutput({name, "_data"}, Aout, v.exp);
    tick();
    checkOutput({name, "_one_cycle"}, out_valid, 0);
  endtask

  initial begin
    vec_t vecs[11];
    vec_t fv;
    int   accepted;
    logic [W-1:0] held;

    vecs[0]  = '{16'h8F00, 4'd4,  1'b0, 16'h08F0};
    vecs[1]  = '{16'h8F00, 4'd4,  1'b1, 16'hF8F0};
    vecs[2]  = '{16'h8000, 4'd15, 1'b1, 16'hFFFF};
    vecs[3]  = '{16'h7FFF, 4'd15, 1'b1, 16'h0000};
    vecs[4]  = '{16'hA5A5, 4'd0,  1'b1, 16'hA5A5};
    vecs[5]  = '{16'h8000, 4'd15, 1'b0, 16'h0001};
    vecs[6]  = '{16'h7FFF, 4'd15, 1'b0, 16'h0000};
    vecs[7]  = '{16'h1234, 4'd0,  1'b0, 16'h1234};
    vecs[8]  = '{16'hFFFF, 4'd8,  1'b0, 16'h00FF};
    vecs[9]  = '{16'hC000, 4'd1,  1'b1, 16'hE000};
    vecs[10] = '{16'h9C3A, 4'd7,  1'b1, 16'hFF38};

    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_aout", Aout, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_in_ready", in_ready, 1);

    for (int i = 0; i < 11; i++) begin
      runOne($sformatf("vec%0d", i), vecs[i]);
    end

    // Throughput: eight shifts of 0x0100 by 0..7 back to back.
    out_ready = 1'b1;
    outCount  = 0;
    gotQ.delete();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 16'h0100, S'(k), 1'b0);
      #1;
      checkOutput($sformatf("thru_in_ready%0d", k), in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    repeat (6) tick();
    checkOutput("thru_count", outCount, 8);
    checkOutput("thru_consecutive", lastOutCycle - firstOutCycle, 7);
    for (int k = 0; k < 8 && k < gotQ.size(); k++) begin
      checkOutput($sformatf("thru_val%0d", k), gotQ[k], 16'h0100 >> k);
    end

    // Backpressure: hold in_valid for six cycles with the consumer stalled.
    out_ready = 1'b0;
    accepted  = 0;
    held      = '0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b1, 16'h1000 + 16'(accepted * 16'h0111), S'(accepted), 1'b0);
      #1;
      if (in_ready) accepted++;
      if (c == 4) held = Aout;
      if (c == 5) checkOutput("bp_aout_stable", Aout, held);
      tick();
    end
    checkOutput("bp_accepted", accepted, 4);
    checkOutput("bp_in_ready_low", in_ready, 0);
    checkOutput("bp_out_valid", out_valid, 1);
    checkOutput("bp_aout_first", Aout, 16'h1000);
    out_ready = 1'b1;
    applyStimulus(1'b1, 16'h5000, 4'd4, 1'b0);
    #1;
    checkOutput("bp_fifth_accept", in_ready, 1);
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    checkOutput("bp_drained", modelQ.size(), 0);

    // Flush with three operations in flight.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 16'hBEEF, S'(k + 1), 1'b1);
      tick();
    end
    in_valid = 1'b0;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_out_valid", out_valid, 0);
    outCount = 0;
    repeat (5) tick();
    checkOutput("flush_no_stale", outCount, 0);
    fv = '{16'hFFFF, 4'd8, 1'b0, 16'h00FF};
    runOne("after_flush", fv);

    // Asynchronous reset with a full, stalled pipeline.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 16'hF0F0, 4'd0, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    checkOutput("prereset_out_valid", out_valid, 1);
    checkOutput("prereset_aout", Aout, 16'hF0F0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out_valid", out_valid, 0);
    checkOutput("async_rst_aout", Aout, 0);
    modelQ.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_in_ready", in_ready, 1);
    fv = '{16'h8F00, 4'd4, 1'b1, 16'hF8F0};
    runOne("post_reset", fv);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      applyStimulus(($urandom % 4) != 0, W'($urandom), S'($urandom), 1'($urandom));
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 25) == 0;
      tick();
    end
    applyStimulus(1'b0, '0, '0, 1'b0);
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
    checkOutput("random_drained", modelQ.size(), 0);
    checkOutput("random_idle", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
